// File: rtl/movegen_pkg.sv
// movegen_pkg: shared constants, move word layout and sequencer state encoding
// for the move-generation scheduler.
package movegen_pkg;
  localparam int NUM_COLS  = 8;
  localparam int MOVE_W    = 16;
  localparam int SCORE_W   = 4;
  localparam int SQ_W      = 6;
  localparam int SCORE_LSB = 12;
  localparam int FROM_LSB  = 6;
  localparam int TO_LSB    = 0;
  localparam int PTR_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GEN,
    ST_DRAIN,
    ST_FIN
  } movegen_state_t;

  function automatic logic [SCORE_W-1:0] move_score(input logic [MOVE_W-1:0] m);
    return m[SCORE_LSB +: SCORE_W];
  endfunction

  function automatic logic [MOVE_W-1:0] make_move(input logic [SCORE_W-1:0] score,
                                                  input logic [SQ_W-1:0] from_sq,
                                                  input logic [SQ_W-1:0] to_sq);
    logic [MOVE_W-1:0] m;
    m = '0;
    m[SCORE_LSB +: SCORE_W] = score;
    m[FROM_LSB +: SQ_W]     = from_sq;
    m[TO_LSB +: SQ_W]       = to_sq;
    return m;
  endfunction
endpackage

// File: rtl/movegen_arb.sv
// movegen_arb: combinational column grant. With MOVEGEN_SCORE_ARB_EN the highest
// score wins and ties fall to round-robin from rr_ptr; otherwise pure round-robin.
module movegen_arb
  import movegen_pkg::*;
(
  input  logic [NUM_COLS-1:0]         col_valid,
  input  logic [NUM_COLS*SCORE_W-1:0] col_score,
  input  logic [PTR_W-1:0]            rr_ptr,
  output logic [NUM_COLS-1:0]         grant,
  output logic                        any_valid
);
  logic [NUM_COLS-1:0] cand;
  logic [PTR_W-1:0]    idx;
  logic                found;

`ifdef MOVEGEN_SCORE_ARB_EN
  logic [SCORE_W-1:0] best;

  always_comb begin
    best = '0;
    for (int k = 0; k < NUM_COLS; k++)
      if (col_valid[k] && (col_score[k*SCORE_W +: SCORE_W] > best))
        best = col_score[k*SCORE_W +: SCORE_W];
    cand = '0;
    for (int k = 0; k < NUM_COLS; k++)
      cand[k] = col_valid[k] && (col_score[k*SCORE_W +: SCORE_W] == best);
  end
`else
  logic unused_score;
  assign unused_score = ^col_score;
  assign cand = col_valid;
`endif

  // first candidate at or after rr_ptr, wrapping 7 -> 0
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      idx = rr_ptr + PTR_W'(i);
      if (cand[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_valid = |col_valid;
endmodule

// File: rtl/movegen_sched.sv
// movegen_sched: sequences a generation pass over the column units and drains their
// move FIFOs onto one valid/ready stream. Build option: MOVEGEN_SCORE_ARB_EN.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | one-cycle col_load strobe, pass counters cleared
// GEN      | columns generating; wait for all done or timeout
// DRAIN    | arbitrate column FIFOs into the output register
// FIN      | one-cycle done pulse
module movegen_sched
  import movegen_pkg::*;
#(
  parameter int GEN_TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_COLS-1:0]        col_done,
  input  logic [NUM_COLS-1:0]        col_valid,
  input  logic [NUM_COLS*MOVE_W-1:0] col_move,
  output logic                       col_load,
  output logic [NUM_COLS-1:0]        col_pop,
  output logic                       move_valid,
  output logic [MOVE_W-1:0]          move_data,
  input  logic                       move_ready,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 move_count,
  output logic                       timeout_err
);
  localparam int TMO_W = $clog2(GEN_TIMEOUT + 1);

  movegen_state_t              state, state_nxt;
  logic [TMO_W-1:0]            gen_cnt;
  logic [PTR_W-1:0]            rr_ptr, grant_idx;
  logic [NUM_COLS-1:0]         grant;
  logic [NUM_COLS*SCORE_W-1:0] col_score;
  logic [MOVE_W-1:0]           grant_move;
  logic any_valid, all_done, gen_tmo, load_ok, grant_en;

  assign all_done = &col_done;
  assign gen_tmo  = (gen_cnt == TMO_W'(GEN_TIMEOUT - 1));
  assign load_ok  = !move_valid || move_ready;

  always_comb begin
    col_score = '0;
    for (int k = 0; k < NUM_COLS; k++)
      col_score[k*SCORE_W +: SCORE_W] = move_score(col_move[k*MOVE_W +: MOVE_W]);
  end

  movegen_arb u_arb (
    .col_valid (col_valid),
    .col_score (col_score),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  always_comb begin
    grant_move = '0;
    grant_idx  = '0;
    for (int k = 0; k < NUM_COLS; k++)
      if (grant[k]) begin
        grant_move = col_move[k*MOVE_W +: MOVE_W];
        grant_idx  = PTR_W'(k);
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_LOAD;
        ST_LOAD:  state_nxt = ST_GEN;
        ST_GEN:   if (all_done || gen_tmo) state_nxt = ST_DRAIN;
        ST_DRAIN: if (!any_valid && (all_done || timeout_err) && load_ok) state_nxt = ST_FIN;
        ST_FIN:   state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // popping on an abort cycle would lose the move, so the grant is suppressed
  always_comb begin
    col_load = (state == ST_LOAD);
    busy     = (state != ST_IDLE);
    done     = (state == ST_FIN);
    grant_en = (state == ST_DRAIN) && load_ok && any_valid && !abort;
    col_pop  = grant_en ? grant : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_valid  <= 1'b0;
      move_data   <= '0;
      move_count  <= '0;
      timeout_err <= 1'b0;
      gen_cnt     <= '0;
      rr_ptr      <= '0;
    end else begin
      if (state == ST_LOAD) begin
        move_count  <= '0;
        timeout_err <= 1'b0;
        gen_cnt     <= '0;
      end
      if (state == ST_GEN) begin
        gen_cnt <= gen_cnt + TMO_W'(1);
        if (!abort && !all_done && gen_tmo) timeout_err <= 1'b1;
      end
      if (abort) move_valid <= 1'b0;
      else if ((state == ST_DRAIN) && load_ok) move_valid <= any_valid;
      if (grant_en) begin
        move_data <= grant_move;
        rr_ptr    <= grant_idx + PTR_W'(1);
        if (move_count != 8'hFF) move_count <= move_count + 8'd1;
      end
    end
  end
endmodule
